// File: rtl/ieee754_to_fixed.sv
// ieee754_to_fixed: converts an IEEE754 single-precision operand into a
// sign plus unsigned fixed-point magnitude (DATA_WIDTH integer bits,
// DATA_WIDTH fraction bits). Fraction bits below the LSB are truncated.
// Optional macro IEEE754_TO_FIXED_BARREL_EN: when defined, the alignment
// shift is done in one cycle by a barrel shifter. When undefined, an
// iterative shifter moves one bit per cycle.
module ieee754_to_fixed #(
  parameter int PRECISION  = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  I_Clk,
  input  logic                  I_nReset,
  input  logic [PRECISION-1:0]  I_Op,
  input  logic                  I_Valid,
  output logic                  O_Ready,
  output logic                  O_Valid,
  input  logic                  I_Ready,
  output logic                  O_Sign,
  output logic [DATA_WIDTH-1:0] O_Int,
  output logic [DATA_WIDTH-1:0] O_Fract,
  output logic                  O_Is_Zero,
  output logic                  O_Overflow,
  output logic                  O_Invalid
);

  localparam int W2    = 2 * DATA_WIDTH;
  localparam int MAX_L = DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [PRECISION-1:0] op_q, op_d;
  logic [W2-1:0]        val_q, val_d;
  logic [7:0]           k_q, k_d;
  logic                 left_q, left_d;
  logic                 sign_q, sign_d;
  logic                 zero_q, zero_d;
  logic                 ovf_q, ovf_d;
  logic                 inv_q, inv_d;

  // Decoded fields of the captured operand.
  logic [7:0]    exp_w;
  logic [7:0]    l_amt;
  logic [7:0]    r_amt;
  logic [W2-1:0] sig_pos;

  assign exp_w = op_q[30:23];
  assign l_amt = exp_w - 8'd127;
  assign r_amt = 8'd127 - exp_w;
  // Significand {1, mantissa} with the hidden bit at the integer LSB (bit DATA_WIDTH).
  assign sig_pos = W2'({1'b1, op_q[22:0]}) << (DATA_WIDTH - 23);

  // State and datapath registers; asynchronous reset aborts any operation.
  always_ff @(posedge I_Clk or negedge I_nReset) begin
    if (!I_nReset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      val_q   <= '0;
      k_q     <= '0;
      left_q  <= 1'b0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      val_q   <= val_d;
      k_q     <= k_d;
      left_q  <= left_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      inv_q   <= inv_d;
    end
  end

  // Next-state and datapath: classify in LOAD, align in LOAD or SHIFT, hold in DONE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    val_d   = val_q;
    k_d     = k_q;
    left_d  = left_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    inv_d   = inv_q;

    case (state_q)
      ST_IDLE: begin
        if (I_Valid) begin
          op_d    = I_Op;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        sign_d  = op_q[31];
        zero_d  = 1'b0;
        ovf_d   = 1'b0;
        inv_d   = 1'b0;
        k_d     = '0;
        left_d  = 1'b0;
        state_d = ST_DONE;
        if (exp_w == 8'd0) begin
          // Zero or denormal: flushed to zero.
          val_d  = '0;
          zero_d = 1'b1;
        end else if (exp_w == 8'd255) begin
          // Inf or NaN.
          val_d = '1;
          inv_d = 1'b1;
        end else if (exp_w >= 8'd127) begin
          if (l_amt > 8'(MAX_L)) begin
            val_d = '1;
            ovf_d = 1'b1;
          end else begin
`ifdef IEEE754_TO_FIXED_BARREL_EN
            val_d = sig_pos << l_amt;
`else
            val_d  = sig_pos;
            k_d    = l_amt;
            left_d = 1'b1;
            if (l_amt != 8'd0) state_d = ST_SHIFT;
`endif
          end
        end else begin
          if (r_amt > 8'(DATA_WIDTH)) begin
            // Magnitude entirely below the fraction LSB.
            val_d  = '0;
            zero_d = 1'b1;
          end else begin
`ifdef IEEE754_TO_FIXED_BARREL_EN
            val_d = sig_pos >> r_amt;
`else
            val_d  = sig_pos;
            k_d    = r_amt;
            left_d = 1'b0;
            state_d = ST_SHIFT;
`endif
          end
        end
      end

      ST_SHIFT: begin
        val_d = left_q ? (val_q << 1) : (val_q >> 1);
        k_d   = k_q - 8'd1;
        if (k_q == 8'd1) state_d = ST_DONE;
      end

      ST_DONE: begin
        if (I_Ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign O_Ready    = (state_q == ST_IDLE) && I_nReset;
  assign O_Valid    = (state_q == ST_DONE);
  assign O_Sign     = sign_q;
  assign O_Int      = val_q[W2-1:DATA_WIDTH];
  assign O_Fract    = val_q[DATA_WIDTH-1:0];
  assign O_Is_Zero  = zero_q;
  assign O_Overflow = ovf_q;
  assign O_Invalid  = inv_q;

endmodule

// File: tb/tb_ieee754_to_fixed.sv
// Testbench for ieee754_to_fixed: randomized operands and backpressure,
// scoreboard of expected results from an arithmetic reference model.
module tb_ieee754_to_fixed;

  localparam int DW = 32;

  logic          clk;
  logic          I_nReset;
  logic [31:0]   I_Op;
  logic          I_Valid;
  logic          O_Ready;
  logic          O_Valid;
  logic          I_Ready;
  logic          O_Sign;
  logic [DW-1:0] O_Int;
  logic [DW-1:0] O_Fract;
  logic          O_Is_Zero;
  logic          O_Overflow;
  logic          O_Invalid;

  ieee754_to_fixed #(.PRECISION(32), .DATA_WIDTH(DW)) dut (
    .I_Clk      (clk),
    .I_nReset   (I_nReset),
    .I_Op       (I_Op),
    .I_Valid    (I_Valid),
    .O_Ready    (O_Ready),
    .O_Valid    (O_Valid),
    .I_Ready    (I_Ready),
    .O_Sign     (O_Sign),
    .O_Int      (O_Int),
    .O_Fract    (O_Fract),
    .O_Is_Zero  (O_Is_Zero),
    .O_Overflow (O_Overflow),
    .O_Invalid  (O_Invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] op;
    logic        sign;
    logic [63:0] mag;
    logic        zero;
    logic        ovf;
    logic        inv;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   lowcnt   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: value = 1.m * 2^(e-127); fixed result = floor(value * 2^32).
  function automatic exp_t model(input logic [31:0] op);
    exp_t r;
    int   e;
    int   s;
    logic [127:0] sig;
    logic [127:0] mag;
    e = int'(op[30:23]);
    r.op = op; r.sign = op[31]; r.mag = '0;
    r.zero = 0; r.ovf = 0; r.inv = 0; r.lat = 2; r.acc = 0;
    sig = 128'({1'b1, op[22:0]});
    if (e == 0) begin
      r.zero = 1;
    end else if (e == 255) begin
      r.inv = 1; r.mag = '1;
    end else begin
      s = e - 150 + DW;
      if (s >= 64) mag = {128{1'b1}};
      else if (s >= 0) mag = sig << s;
      else mag = sig >> (-s);
      if (mag >= (128'd1 << 64)) begin
        r.ovf = 1; r.mag = '1;
      end else if (mag == 0) begin
        r.zero = 1;
      end else begin
        r.mag = mag[63:0];
`ifndef IEEE754_TO_FIXED_BARREL_EN
        r.lat = 2 + ((e >= 127) ? (e - 127) : (127 - e));
`endif
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 3) != 0) v[30:23] = 8'($urandom_range(90, 165));
    return v;
  endfunction

  // Downstream readiness: random, with occasional 5-cycle stall bursts.
  task automatic step_ready();
    if (lowcnt > 0) begin
      I_Ready = 1'b0;
      lowcnt--;
    end else begin
      I_Ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) lowcnt = 5;
    end
  endtask

  // Monitor: pops the scoreboard on each new result, checks holding while stalled.
  logic        prev_v  = 1'b0;
  logic        prev_hs = 1'b0;
  logic [98:0] held;
  initial begin
    exp_t ex;
    forever begin
      @(negedge clk);
      #2;
      if (!I_nReset) begin
        prev_v = 1'b0; prev_hs = 1'b0;
        continue;
      end
      if (O_Valid) begin
        chk("ready_low_in_done", 64'(O_Ready), 64'd0);
        if (prev_v && !prev_hs) begin
          chk("hold_stable", 64'({O_Sign, O_Int, O_Fract, O_Is_Zero, O_Overflow} ^ held[98:1]) , 64'd0);
          chk("hold_invalid", 64'(O_Invalid), 64'(held[0]));
        end else if (sb_q.size() == 0) begin
          chk("unexpected_valid", 64'(O_Valid), 64'd0);
        end else begin
          ex = sb_q.pop_front();
          chk("sign", 64'(O_Sign), 64'(ex.sign));
          chk("int", 64'(O_Int), 64'(ex.mag[63:32]));
          chk("fract", 64'(O_Fract), 64'(ex.mag[31:0]));
          chk("is_zero", 64'(O_Is_Zero), 64'(ex.zero));
          chk("overflow", 64'(O_Overflow), 64'(ex.ovf));
          chk("invalid", 64'(O_Invalid), 64'(ex.inv));
          chk("latency", 64'(cyc - ex.acc), 64'(ex.lat));
          $display("op=0x%08h sign=%0b int=0x%08h fract=0x%08h z=%0b o=%0b i=%0b lat=%0d",
                   ex.op, O_Sign, O_Int, O_Fract, O_Is_Zero, O_Overflow, O_Invalid, cyc - ex.acc);
        end
        held = {O_Sign, O_Int, O_Fract, O_Is_Zero, O_Overflow, O_Invalid};
      end
      if (sb_q.size() > 0 && (cyc - sb_q[0].acc) > 200) begin
        chk("result_timeout", 64'(cyc - sb_q[0].acc), 64'(sb_q[0].lat));
        void'(sb_q.pop_front());
      end
      prev_v  = O_Valid;
      prev_hs = O_Valid && I_Ready;
    end
  end

  logic [31:0] dir_ops [14] = '{
    32'h3FC00000, 32'hC1200000, 32'h3E800000, 32'h4F800000, 32'h7FC00000,
    32'h00000001, 32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
    32'h4F7FFFFF, 32'h2F800000, 32'h2F000000, 32'hBF800000
  };

  // Stimulus driver.
  initial begin
    exp_t        ex;
    logic [31:0] op;
    bit          accepted;
    int          acc;
    I_nReset = 1'b0; I_Valid = 1'b0; I_Op = '0; I_Ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(O_Valid), 64'd0);
    chk("rst_ready", 64'(O_Ready), 64'd0);
    chk("rst_outs", 64'({O_Sign, O_Int, O_Fract} != 0), 64'd0);
    chk("rst_flags", 64'({O_Is_Zero, O_Overflow, O_Invalid}), 64'd0);
    I_nReset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(O_Ready), 64'd1);

    for (int n = 0; n < 250; n++) begin
      op = (n < 14) ? dir_ops[n] : rand_op();
      accepted = 0;
      for (int t = 0; t < 300 && !accepted; t++) begin
        @(negedge clk);
        step_ready();
        I_Valid = ($urandom_range(0, 3) != 0);
        I_Op    = I_Valid ? op : $urandom;
        #1;
        if (I_Valid && O_Ready) begin
          ex = model(op);
          ex.acc = cyc;
          sb_q.push_back(ex);
          accepted = 1;
        end
      end
      if (!accepted) begin
        $display("FAIL accept_timeout: got no O_Ready expected accept of 0x%08h", op);
        failures++;
        $fatal(1, "accept timeout");
      end
    end

    for (int t = 0; t < 2000 && sb_q.size() > 0; t++) begin
      @(negedge clk);
      step_ready();
      I_Valid = 1'b0;
    end
    chk("drain", 64'(sb_q.size()), 64'd0);

    // Abort mid-shift with reset: no result may appear.
    lowcnt = 0;
    I_Ready = 1'b1;
    @(negedge clk);
    I_Op = 32'h3E800000; I_Valid = 1'b1;
    #1 chk("abort_ready", 64'(O_Ready), 64'd1);
    acc = cyc;
    @(negedge clk);
    I_Valid = 1'b0;
    @(negedge clk);
    #3 I_nReset = 1'b0;
    #1;
    chk("abort_outs", 64'({O_Sign, O_Int, O_Fract} != 0), 64'd0);
    chk("abort_flags", 64'({O_Is_Zero, O_Overflow, O_Invalid}), 64'd0);
    chk("abort_valid", 64'(O_Valid), 64'd0);
    chk("abort_ready_low", 64'(O_Ready), 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_hold_valid", 64'(O_Valid), 64'd0);
    end
    I_nReset = 1'b1;
    #1 chk("abort_release_ready", 64'(O_Ready), 64'd1);
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      #1 chk("abort_no_valid", 64'(O_Valid), 64'd0);
    end
    $display("abort test op=0x3e800000 accepted at cycle %0d", acc);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
